pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 3-stage RV32I core (S1 fetch/decode, S2 execute, S3 memory/writeback). It owns the PC select mux, per-stage stall and flush signals, load-use interlock, branch/jump redirect, memory-wait freeze and post-reset boot sequencing. It also keeps stall/flush performance counters readable through the CSR path. S3 per-instruction control decode stays in the stage-3 decoder; this block only sequences the stages.

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl_hazard_detect.sv | 69 ++++++
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared opcode, pc-select, NOP and FSM definitions for pipeline sequencing
//
// Purpose: single source for the RV32I major-opcode values (instr[6:2]), the
// fetch-mux pc_sel encodings and the NOP used for flushed stage registers, so
// the fetch mux, decoders and pipe_ctrl all agree.
// Ports: none (package).

package pipe_ctrl_pkg;

  // Major opcodes, instr[6:2] (instr[1:0] is always 2'b11 for 32-bit encodings)
  localparam logic [4:0] OPC_LOAD_5   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM_5 = 5'b00100;
  localparam logic [4:0] OPC_STORE_5  = 5'b01000;
  localparam logic [4:0] OPC_OP_5     = 5'b01100;
  localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
  localparam logic [4:0] OPC_JALR_5   = 5'b11001;
  localparam logic [4:0] OPC_JAL_5    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM_5 = 5'b11100;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_ALU   = 2'd1,
    PC_JAL   = 2'd2,
    PC_RST   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_e;

  function automatic logic is_mem_opc(input logic [4:0] opc);
    return (opc == OPC_LOAD_5) || (opc == OPC_STORE_5);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stage-control bundle between the datapath and pipe_ctrl
//
// Purpose: groups the instruction/branch/memory status coming from the
// datapath and the pc-select, stall, flush and counter outputs going back.
// Modports:
//   master - pipe_ctrl side: reads instr_s1/s2, br_taken_s2, br_pred_s2,
//            mem_busy; drives pc_sel, stall_s1..s3, flush_s1/s2, counters.
//   slave  - datapath side, directions mirrored.

interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr_s1;
  logic [31:0]      instr_s2;
  logic             br_taken_s2;
  logic             br_pred_s2;
  logic             mem_busy;
  logic [1:0]       pc_sel;
  logic             stall_s1;
  logic             stall_s2;
  logic             stall_s3;
  logic             flush_s1;
  logic             flush_s2;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  instr_s1, instr_s2, br_taken_s2, br_pred_s2, mem_busy,
    output pc_sel, stall_s1, stall_s2, stall_s3, flush_s1, flush_s2,
    output stall_cnt, flush_cnt
  );

  modport slave (
    output instr_s1, instr_s2, br_taken_s2, br_pred_s2, mem_busy,
    input  pc_sel, stall_s1, stall_s2, stall_s3, flush_s1, flush_s2,
    input  stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational load-use hazard detection
//
// Purpose: flags when the load in S2 writes a register the S1 instruction
// reads, so S1 must wait one cycle for the load data.
// Ports:
//   instr_s1  in  32  instruction in S1 (consumer)
//   instr_s2  in  32  instruction in S2 (possible load)
//   load_use  out 1   S2 is a load with rd != x0 that S1 reads via rs1/rs2

module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr_s1,
  input  logic [31:0] instr_s2,
  output logic        load_use
);

  logic [4:0] s1_opc;
  logic [4:0] s2_opc;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       s2_load;
  logic       unused_bits;

  assign s1_opc = instr_s1[6:2];
  assign s2_opc = instr_s2[6:2];
  assign rs1    = instr_s1[19:15];
  assign rs2    = instr_s1[24:20];
  assign funct3 = instr_s1[14:12];
  assign rd     = instr_s2[11:7];

  // Register-read usage follows the instruction format: R/S/B read both,
  // I-type reads rs1 only, U/J read nothing.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (s1_opc)
      OPC_OP_5, OPC_STORE_5, OPC_BRANCH_5: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP_IMM_5, OPC_LOAD_5, OPC_JALR_5: begin
        uses_rs1 = 1'b1;
      end
      // Register-form CSR ops (csrrw/csrrs/csrrc) read rs1; the immediate
      // forms and ecall/ebreak do not.
      OPC_SYSTEM_5: begin
        uses_rs1 = !funct3[2] && (funct3[1:0] != 2'b00);
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // A load into x0 produces nothing to forward, so it never interlocks.
  assign s2_load  = (s2_opc == OPC_LOAD_5) && (rd != 5'd0);

  assign load_use = s2_load && ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));

  assign unused_bits = ^{instr_s1[31:25], instr_s1[11:7], instr_s1[1:0],
                         instr_s2[31:12], instr_s2[1:0]};

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencing controller for the 3-stage RV32I core
//
// Purpose: drives the PC select mux and per-stage stall/flush controls:
// post-reset boot flush, memory-wait freeze, S2 branch/JALR redirect,
// load-use interlock and S1 JAL redirect, plus stall/flush perf counters.
// Parameters:
//   BOOT_CYCLES  cycles after reset release during which S2/S3 are flushed
//   CNT_W        perf counter width
// Ports:
//   clk  in   core clock
//   rst  in   synchronous, active-high reset
//   bus  pipe_ctrl_if.master: instr_s1/s2, br_taken_s2, br_pred_s2, mem_busy
//        in; pc_sel, stall_s1..s3, flush_s1/s2, stall_cnt, flush_cnt out

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus
);

  localparam int BOOT_W = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

  state_e            state;
  state_e            state_nxt;
  logic [BOOT_W-1:0] boot_cnt;
  logic [4:0]        s3_opc;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  logic [4:0]        s1_opc;
  logic [4:0]        s2_opc;
  logic              load_use;
  logic              s2_redirect;
  logic              s1_jal;
  logic              freeze;

  pc_sel_e           pc_sel;
  logic              stall_s1;
  logic              stall_s2;
  logic              stall_s3;
  logic              flush_s1;
  logic              flush_s2;

  hazard_detect u_hazard_detect (
    .instr_s1 (bus.instr_s1),
    .instr_s2 (bus.instr_s2),
    .load_use (load_use)
  );

  assign s1_opc = bus.instr_s1[6:2];
  assign s2_opc = bus.instr_s2[6:2];

  assign s2_redirect = (s2_opc == OPC_JALR_5) ||
                       ((s2_opc == OPC_BRANCH_5) && (bus.br_taken_s2 != bus.br_pred_s2));
  assign s1_jal      = (s1_opc == OPC_JAL_5);

  // The S3 instruction is not a port: this block already knows what moves
  // from S2 into S3, so it tracks the S3 opcode itself. In MEMWAIT S3 is held,
  // so only mem_busy decides when the freeze ends.
  assign freeze = bus.mem_busy &&
                  ((state == ST_MEMWAIT) || ((state == ST_RUN) && is_mem_opc(s3_opc)));

  always_comb begin
    state_nxt = state;
    pc_sel    = PC_PLUS4;
    stall_s1  = 1'b0;
    stall_s2  = 1'b0;
    stall_s3  = 1'b0;
    flush_s1  = 1'b0;
    flush_s2  = 1'b0;

    if (rst) begin
      state_nxt = ST_BOOT;
      pc_sel    = PC_RST;
      flush_s1  = 1'b1;
      flush_s2  = 1'b1;
    end else begin
      case (state)
        ST_BOOT: begin
          flush_s1 = 1'b1;
          flush_s2 = 1'b1;
          // The counter reaches 0 at this edge, so the next cycle is RUN.
          if (boot_cnt <= BOOT_W'(1)) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN, ST_MEMWAIT: begin
          if (freeze) begin
            state_nxt = ST_MEMWAIT;
            stall_s1  = 1'b1;
            stall_s2  = 1'b1;
            stall_s3  = 1'b1;
          end else begin
            // A redirect deferred by the freeze fires on the first unfrozen
            // cycle because S2 held its inputs stable.
            state_nxt = ST_RUN;
            if (s2_redirect) begin
              pc_sel   = PC_ALU;
              flush_s1 = 1'b1;
              flush_s2 = 1'b1;
            end else if (load_use) begin
              // Hold S1, bubble into S2; a JAL in S1 redirects next cycle.
              stall_s1 = 1'b1;
              flush_s2 = 1'b1;
            end else if (s1_jal) begin
              pc_sel   = PC_JAL;
              flush_s1 = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = ST_BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_BOOT;
      boot_cnt  <= BOOT_W'(BOOT_CYCLES);
      s3_opc    <= NOP_INSTR[6:2];
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;

      if ((state == ST_BOOT) && (boot_cnt != '0)) begin
        boot_cnt <= boot_cnt - BOOT_W'(1);
      end

      // Boot flushes S3 as well, so whatever S2 showed is not tracked.
      if (state == ST_BOOT) begin
        s3_opc <= NOP_INSTR[6:2];
      end else if (!stall_s3) begin
        s3_opc <= s2_opc;
      end

      if (stall_s1 || stall_s2 || stall_s3) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end

      if ((flush_s1 || flush_s2) && (state != ST_BOOT)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_sel    = pc_sel;
  assign bus.stall_s1  = stall_s1;
  assign bus.stall_s2  = stall_s2;
  assign bus.stall_s3  = stall_s3;
  assign bus.flush_s1  = flush_s1;
  assign bus.flush_s2  = flush_s2;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural pipeline model

module tb_pipe_ctrl;

  localparam int BOOT = 2;
  localparam int CW   = 32;

  localparam logic [31:0] I_NOP     = 32'h0000_0013;
  localparam logic [31:0] I_LW_X5   = 32'h0000_A283; // lw x5,0(x1)
  localparam logic [31:0] I_LW_X0   = 32'h0000_A003; // lw x0,0(x1)
  localparam logic [31:0] I_LW_X1   = 32'h0001_2083; // lw x1,0(x2)
  localparam logic [31:0] I_ADD     = 32'h0022_8333; // add x6,x5,x2
  localparam logic [31:0] I_ADDI    = 32'h0012_8393; // addi x7,x5,1
  localparam logic [31:0] I_BEQ     = 32'h0020_8463; // beq x1,x2,+8
  localparam logic [31:0] I_BNE     = 32'h0002_9463; // bne x5,x0,+8
  localparam logic [31:0] I_SW      = 32'h0020_A023; // sw x2,0(x1)
  localparam logic [31:0] I_SW_X5   = 32'h0050_A223; // sw x5,4(x1)
  localparam logic [31:0] I_JAL     = 32'h0100_00EF; // jal x1,+16
  localparam logic [31:0] I_JALR    = 32'h0000_8067; // jalr x0,0(x1)
  localparam logic [31:0] I_LUI     = 32'h0000_12B7; // lui x5,1

  localparam logic [31:0] POOL [13] = '{I_NOP, I_LW_X5, I_LW_X0, I_LW_X1, I_ADD, I_ADDI,
                                        I_BEQ, I_BNE, I_SW, I_SW_X5, I_JAL, I_JALR, I_LUI};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;

  // model state: boot cycles left, instruction sitting in S3, counters
  int          boot_left = 0;
  logic [31:0] s3_ins    = I_NOP;
  logic [31:0] m_scnt    = '0;
  logic [31:0] m_fcnt    = '0;
  bit          cnt_known = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got 0x%0h, want 0x%0h", tag, cyc_n, obs, exp);
    end
  endtask

  function automatic bit reads_rs1(input logic [31:0] i);
    case (i[6:0])
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67: return 1'b1;
      7'h73: return (i[14] == 1'b0) && (i[13:12] != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit reads_rs2(input logic [31:0] i);
    return (i[6:0] == 7'h33) || (i[6:0] == 7'h23) || (i[6:0] == 7'h63);
  endfunction

  function automatic bit is_mem(input logic [31:0] i);
    return (i[6:0] == 7'h03) || (i[6:0] == 7'h23);
  endfunction

  task automatic cyc(input logic r, input logic [31:0] s1, input logic [31:0] s2,
                     input logic tk, input logic pd, input logic busy);
    logic [1:0] e_pc;
    logic       e_st1, e_stall, e_f1, e_f2;
    bit         lu;
    @(negedge clk);
    rst             = r;
    bus.instr_s1    = s1;
    bus.instr_s2    = s2;
    bus.br_taken_s2 = tk;
    bus.br_pred_s2  = pd;
    bus.mem_busy    = busy;
    #1;
    e_pc = 2'd0; e_st1 = 1'b0; e_stall = 1'b0; e_f1 = 1'b0; e_f2 = 1'b0;
    lu = (s2[6:0] == 7'h03) && (s2[11:7] != 5'd0) &&
         ((reads_rs1(s1) && (s1[19:15] == s2[11:7])) ||
          (reads_rs2(s1) && (s1[24:20] == s2[11:7])));
    if (r) begin
      e_pc = 2'd3; e_f1 = 1'b1; e_f2 = 1'b1;
    end else if (boot_left > 0) begin
      e_f1 = 1'b1; e_f2 = 1'b1;
    end else if (busy && is_mem(s3_ins)) begin
      e_stall = 1'b1; e_st1 = 1'b1;
    end else if ((s2[6:0] == 7'h67) || ((s2[6:0] == 7'h63) && (tk != pd))) begin
      e_pc = 2'd1; e_f1 = 1'b1; e_f2 = 1'b1;
    end else if (lu) begin
      e_st1 = 1'b1; e_f2 = 1'b1;
    end else if (s1[6:0] == 7'h6F) begin
      e_pc = 2'd2; e_f1 = 1'b1;
    end
    check_eq("pc_sel",   32'(bus.pc_sel),   32'(e_pc));
    check_eq("stall_s1", 32'(bus.stall_s1), 32'(e_st1));
    check_eq("stall_s2", 32'(bus.stall_s2), 32'(e_stall));
    check_eq("stall_s3", 32'(bus.stall_s3), 32'(e_stall));
    check_eq("flush_s1", 32'(bus.flush_s1), 32'(e_f1));
    check_eq("flush_s2", 32'(bus.flush_s2), 32'(e_f2));
    if (cnt_known) begin
      check_eq("stall_cnt", bus.stall_cnt, m_scnt);
      check_eq("flush_cnt", bus.flush_cnt, m_fcnt);
    end
    @(posedge clk);
    cyc_n++;
    if (r) begin
      boot_left = BOOT;
      s3_ins    = I_NOP;
      m_scnt    = '0;
      m_fcnt    = '0;
      cnt_known = 1;
    end else begin
      if (e_st1 || e_stall) m_scnt = m_scnt + 1;
      if ((e_f1 || e_f2) && (boot_left == 0)) m_fcnt = m_fcnt + 1;
      if (boot_left > 0) begin
        boot_left--;
        s3_ins = I_NOP;
      end else if (!e_stall) begin
        s3_ins = s2;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_s1 = I_NOP; bus.instr_s2 = I_NOP;
    bus.br_taken_s2 = 1'b0; bus.br_pred_s2 = 1'b0; bus.mem_busy = 1'b0;

    // reset and boot sequence
    repeat (3) cyc(1'b1, I_NOP, I_NOP, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, I_NOP, I_NOP, 1'b0, 1'b0, 1'b0);

    // load-use, then the bubble, then rd = x0
    cyc(1'b0, I_ADD,  I_LW_X5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, I_ADD,  I_NOP,   1'b0, 1'b0, 1'b0);
    cyc(1'b0, I_ADD,  I_LW_X0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, I_SW_X5, I_LW_X5, 1'b0, 1'b0, 1'b0);

    // mispredicted and correctly predicted branch
    cyc(1'b0, I_ADD, I_BEQ, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, I_ADD, I_BEQ, 1'b1, 1'b1, 1'b0);

    // store into S3, then memory wait with a pending mispredict in S2
    cyc(1'b0, I_BEQ, I_SW, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, I_ADD, I_BEQ, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, I_ADD, I_BEQ, 1'b0, 1'b1, 1'b0);

    // load-use on jalr in S1, then a JAL in S1 redirects
    cyc(1'b0, I_JALR, I_LW_X1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, I_JALR, I_NOP,   1'b0, 1'b0, 1'b0);
    cyc(1'b0, I_JAL,  I_JALR,  1'b0, 1'b0, 1'b0);
    cyc(1'b0, I_JAL,  I_NOP,   1'b0, 1'b0, 1'b0);

    // reset asserted in the middle of a memory wait
    cyc(1'b0, I_NOP, I_LW_X5, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, I_NOP, I_JALR, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, I_NOP, I_JALR, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, I_NOP, I_JALR, 1'b0, 1'b0, 1'b1);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = POOL[$urandom_range(0, 12)];
      b = POOL[$urandom_range(0, 12)];
      cyc(($urandom_range(0, 63) == 0), a, b, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
